// File: rtl/uart_tx_serializer.sv
// UART transmitter: pops bytes from an upstream FIFO and serializes them 8N1, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic [7:0] fifo_odata,
  input  logic       fifo_empty,
  output logic       fifo_pop,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shreg_q;
  logic        bit_end;

  assign bit_end = (cnt_q == LAST_CNT);

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    tx       = 1'b1;
    busy     = 1'b1;
    tx_done  = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (tx_en && !fifo_empty && !rst) begin
          fifo_pop = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        tx = shreg_q[0];
        if (bit_end && (idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      // Eight rotations have restored the original byte, so its XOR is the parity.
      PARITY: begin
        tx = ^shreg_q;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        tx = 1'b1;
        if (bit_end) begin
          tx_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) begin
        shreg_q <= fifo_odata;
        cnt_q   <= '0;
        idx_q   <= '0;
      end else if (state_q != IDLE) begin
        if (bit_end) begin
          cnt_q <= '0;
          // Rotate rather than shift so the byte is intact again after bit 7.
          if (state_q == DATA) begin
            shreg_q <= {shreg_q[0], shreg_q[7:1]};
            idx_q   <= idx_q + 3'd1;
          end
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: FIFO model plus a frame-waveform reference model checked every cycle.
module tb_uart_tx_serializer;
  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * C;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_odata = 8'h00;
  logic       fifo_pop, tx, busy, tx_done;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_odata(fifo_odata),
    .fifo_empty(fifo_empty), .fifo_pop(fifo_pop), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t vecs[6];

  logic [7:0] fq[$];
  logic       exp_q[$];
  logic       cap_q[$];
  int   checks = 0, failures = 0, n_pop = 0, n_done = 0, cyc = 0;
  logic pend = 1'b0;
  logic e_pop, e_tx, e_busy, e_done;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Expected line levels for one whole frame, one entry per clock.
  function automatic void build_frame(input logic [7:0] b);
    logic lv[$];
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    lv.push_back(^b);
`endif
    lv.push_back(1'b1);
    foreach (lv[k]) for (int r = 0; r < C; r++) exp_q.push_back(lv[k]);
  endfunction

  function automatic void model_cycle();
    if (rst) begin
      exp_q.delete();
      e_pop = 1'b0; e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    end else if (exp_q.size() == 0) begin
      e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      e_pop = tx_en && (fq.size() > 0);
      if (e_pop) build_frame(fq[0]);
    end else begin
      e_tx   = exp_q.pop_front();
      e_busy = 1'b1;
      e_done = (exp_q.size() == 0);
      e_pop  = 1'b0;
    end
  endfunction

  function automatic logic [7:0] decode(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = cap_q[base + (1 + i) * C + C / 2];
    return b;
  endfunction

  // One clock: present FIFO head, sample and compare mid-cycle, then advance to the next negedge.
  task automatic step();
    fifo_empty = (fq.size() == 0);
    fifo_odata = (fq.size() > 0) ? fq[0] : 8'h00;
    #1;
    model_cycle();
    check($sformatf("cyc%0d pop/tx/busy/done", cyc),
          {28'd0, fifo_pop, tx, busy, tx_done}, {28'd0, e_pop, e_tx, e_busy, e_done});
    if (fifo_pop === 1'b1) begin n_pop++; pend = 1'b1; end
    if (tx_done === 1'b1) n_done++;
    if (busy === 1'b1) cap_q.push_back(tx);
    cyc++;
    @(negedge clk);
    if (pend) begin
      if (fq.size() > 0) void'(fq.pop_front());
      pend = 1'b0;
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = n_done;
    for (int i = 0; i < budget && n_done == d0; i++) step();
    check({name, " done_seen"}, 32'(n_done != d0), 32'd1);
  endtask

  task automatic wait_pop(input string name, input int budget);
    int p0 = n_pop;
    for (int i = 0; i < budget && n_pop == p0; i++) step();
    check({name, " pop_seen"}, 32'(n_pop != p0), 32'd1);
  endtask

  initial begin
    int p0, d0;
    logic [7:0] exp3[3];
    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'hA3, 1'b0};
    vecs[3] = '{8'h00, 1'b0};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'hFF, 1'b0};
    exp3[0] = 8'hA3; exp3[1] = 8'h3C; exp3[2] = 8'hFF;

    // Reset with data waiting and tx_en high: nothing may pop.
    #1 rst = 1'b1;
    @(negedge clk);
    fq.push_back(8'h5A);
    tx_en = 1'b1;
    repeat (3) step();
    check("pops_during_reset", n_pop, 0);
    rst = 1'b0;
    wait_done("post_reset_frame", 100);
    step();

    // Single-frame vectors.
    for (int v = 0; v < 6; v++) begin
      cap_q.delete();
      fq.push_back(vecs[v].data);
      tx_en = 1'b1;
      wait_done($sformatf("vec%0d", v), 200);
      step(); step();
      check($sformatf("vec%0d busy_len", v), cap_q.size(), FRAME);
      if (cap_q.size() >= FRAME) begin
        check($sformatf("vec%0d start", v), 32'(cap_q[C / 2]), 32'd0);
        check($sformatf("vec%0d data", v), 32'(decode(0)), 32'(vecs[v].data));
`ifdef UART_TX_PARITY_EN
        check($sformatf("vec%0d parity", v), 32'(cap_q[9 * C + C / 2]), 32'(vecs[v].par));
`endif
        check($sformatf("vec%0d stop", v), 32'(cap_q[FRAME - 1]), 32'd1);
      end
    end

    // Three bytes back to back.
    cap_q.delete();
    p0 = n_pop; d0 = n_done;
    for (int i = 0; i < 3; i++) fq.push_back(exp3[i]);
    for (int i = 0; i < 400 && (n_done - d0) < 3; i++) step();
    step(); step();
    check("b2b pops", n_pop - p0, 3);
    check("b2b dones", n_done - d0, 3);
    check("b2b busy_len", cap_q.size(), 3 * FRAME);
    if (cap_q.size() >= 3 * FRAME)
      for (int f = 0; f < 3; f++)
        check($sformatf("b2b byte%0d", f), 32'(decode(f * FRAME)), 32'(exp3[f]));

    // tx_en dropped mid-frame.
    p0 = n_pop; d0 = n_done;
    fq.push_back(8'h12); fq.push_back(8'h34);
    wait_pop("en_drop", 20);
    repeat (12) step();
    tx_en = 1'b0;
    repeat (100) step();
    check("en_drop pops", n_pop - p0, 1);
    check("en_drop dones", n_done - d0, 1);
    tx_en = 1'b1;
    wait_done("en_drop resume", 200);
    check("en_drop pops_after", n_pop - p0, 2);

    // Asynchronous reset in data bit 3.
    p0 = n_pop; d0 = n_done;
    fq.push_back(8'h96); fq.push_back(8'hC3);
    wait_pop("rst_mid", 20);
    repeat (17) step();
    #2 rst = 1'b1;
    #1;
    check("async_rst tx/busy/pop", {29'd0, tx, busy, fifo_pop}, {29'd0, 1'b1, 1'b0, 1'b0});
    repeat (3) step();
    check("rst_mid pops_in_reset", n_pop - p0, 1);
    rst = 1'b0;
    cap_q.delete();
    wait_done("rst_mid next", 200);
    check("rst_mid dones", n_done - d0, 1);
    if (cap_q.size() >= FRAME) check("rst_mid next_byte", 32'(decode(0)), 32'hC3);
    else check("rst_mid next_len", cap_q.size(), FRAME);

    // Empty FIFO with tx_en high.
    p0 = n_pop;
    repeat (100) step();
    check("empty pops", n_pop - p0, 0);

    // Random traffic, tx_en toggling and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if (rst) begin
        if ($urandom_range(0, 1) == 0) rst = 1'b0;
      end else if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) tx_en = ~tx_en;
      if (fq.size() < 8 && $urandom_range(0, 29) == 0) fq.push_back(8'($urandom));
      step();
    end
    rst = 1'b0;
    tx_en = 1'b1;
    for (int i = 0; i < 9 * (FRAME + 2) && (fq.size() > 0 || exp_q.size() > 0); i++) step();
    check("random drained", 32'(fq.size() + exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
